axi_mem_responder: RTL
======================

# axi_mem_responder

AXI-style slave memory model that answers the 512-bit master ports (`ar*`/`r*`/`aw*`/`w*`/`b*`) driven by the PageRank engine. It holds a line-addressed backing store, returns read bursts after a programmable latency, commits strobed write bursts and issues write responses. It sits opposite the accelerator in simulation and bring-up benches. A backdoor port preloads graph arrays before a run, and counters expose traffic totals.

## Interface
Parameters:
- `DATA_W`, 512, data beat width; one beat = one 64-byte line
- `ID_W`, 16, transaction ID width
- `LOG_LINES`, 10, log2 of backing-store depth in lines
- `BASE_ADDR`, 64'h0, byte address of line 0
- `RD_LATENCY`, 4, cycles from AR handshake to first `rvalid_s` (legal range ≥1)

Ports:
- `clk` in 1: single clock
- `reset_n` in 1: asynchronous, active-low reset
- `arid_s` in 16, `araddr_s` in 64, `arlen_s` in 8, `arsize_s` in 3, `arvalid_s` in 1, `arready_s` out 1: read address channel
- `rid_s` out 16, `rdata_s` out 512, `rresp_s` out 2, `rlast_s` out 1, `rvalid_s` out 1, `rready_s` in 1: read data channel
- `awid_s` in 16, `awaddr_s` in 64, `awlen_s` in 8, `awsize_s` in 3, `awvalid_s` in 1, `awready_s` out 1: write address channel
- `wid_s` in 16, `wdata_s` in 512, `wstrb_s` in 64, `wlast_s` in 1, `wvalid_s` in 1, `wready_s` out 1: write data channel
- `bid_s` out 16, `bresp_s` out 2, `bvalid_s` out 1, `bready_s` in 1: write response channel
- `ld_valid` in 1, `ld_line` in `LOG_LINES`, `ld_data` in 512: backdoor full-line write
- `rd_beats` out 32, `wr_beats` out 32: beats completed since reset

## Operation
- Line index = `(addr - BASE_ADDR) >> 6`. `addr[5:0]` is ignored, so the whole aligned line is returned. The master selects the word itself.
- A beat is in range iff `BASE_ADDR ≤ addr` and index < 2^`LOG_LINES`. Range is checked per beat.
- Bursts are INCR only. Beat k uses index base+k. `arsize_s`, `awsize_s` and `wid_s` are ignored.
- Read FSM: R_IDLE → (AR handshake) → R_WAIT → R_DATA → R_IDLE.
  - R_IDLE: `arready_s`=1. On handshake, latch id, line and `arlen_s`+1; load a countdown of `RD_LATENCY`-1.
  - R_WAIT: decrement the countdown; at 0, enter R_DATA.
  - R_DATA: `rvalid_s`=1. `rdata_s` = mem[line] if in range, else 0 with `rresp_s`=2'b10; otherwise `rresp_s`=2'b00. `rid_s` = latched id. `rlast_s`=1 on the final beat.
  - On `rvalid_s & rready_s`: advance to the next beat, or return to R_IDLE after the last beat.
- Write FSM: W_IDLE → (AW handshake) → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: `awready_s`=1. On handshake, latch id, line and beat count.
  - W_DATA: `wready_s`=1. On each W handshake, byte i of mem[line] takes `wdata_s` byte i where `wstrb_s[i]`=1; out-of-range beats are dropped.
  - The burst ends after `awlen_s`+1 beats regardless of `wlast_s`.
  - Error flag is set if `wlast_s` disagrees with the final-beat position or any beat was out of range.
  - W_RESP: `bvalid_s`=1, `bid_s` = latched id, `bresp_s` = error ? 2'b10 : 2'b00. Held until `bready_s`, then W_IDLE.
- Read and write FSMs are independent and run concurrently. One outstanding transaction per direction.
- Backdoor: `ld_valid` writes `ld_data` to mem[`ld_line`] at the edge. If an AXI write beat hits the same line in the same cycle, the AXI bytes win for strobed lanes.
- `rd_beats` / `wr_beats` increment on each R / W handshake and wrap at 2^32.

## Timing
- Reset (`reset_n` low, asynchronous): both FSMs go idle; all outputs are 0, including `arready_s`, `awready_s`, counters, `rdata_s` and ids. Memory contents are not cleared.
- Ready after reset: `arready_s` and `awready_s` rise at the first `clk` edge after `reset_n` deasserts.
- Reset mid-burst: the transaction is abandoned with no response. Writes already committed stay committed.
- Handshake timing: `arready_s` and `awready_s` fall at the handshake edge and rise again the edge after the final R handshake or the B handshake.
- Read latency: AR handshake at edge N gives the first `rvalid_s` after edge N+`RD_LATENCY`. Back-to-back beats stream one per cycle while `rready_s`=1.
- Read stall: while `rvalid_s` & !`rready_s`, `rdata_s`, `rresp_s`, `rlast_s` and `rid_s` are stable. Data is sampled from mem when a beat is first presented; a write to that line during a stall does not alter the held beat.
- Write timing: `wready_s` rises the edge after the AW handshake. `bvalid_s` rises the edge after the final W handshake.
- Simultaneous AR and AW handshakes in one cycle are both accepted.

## Test plan
- Preload line 3 = pattern P via backdoor. AR addr=`BASE_ADDR`+0xC8 (offset 8 within line 3), len 0, id 2 → after 4 cycles, `rdata_s`=P, `rid_s`=2, `rlast_s`=1, `rresp_s`=0.
- AW addr line 5, len 0, id 0; W with `wstrb_s`=64'h00000000000000FF, `wlast_s`=1 → only bytes 0-7 of line 5 change; `bvalid_s` next cycle with `bresp_s`=0. A subsequent read confirms the other 56 bytes are unchanged.
- Read burst len 3 from line 2^`LOG_LINES`-2 with `rready_s` toggling 1/0 → 4 beats; beats 0-1 return data with OKAY, beats 2-3 return 0 with `rresp_s`=2'b10; data is held during stalls; `rlast_s` only on beat 4; `rd_beats`=4.
- W burst len 1 with `wlast_s`=1 on both beats → both beats written; `bresp_s`=2'b10.
- Concurrent read of line 7 and write of line 9 issued in the same cycle → both complete independently with correct ids. Assert `reset_n` mid-read-burst → all outputs are 0 immediately, and `arready_s`=1 one edge after release.

Source files
------------

// File: rtl/axi_mem_responder_if.sv
// axi_mem_responder_if: AXI read/write channel bundle between a 512-bit master and the memory model
// Ports: ar*/r* read address and data channels, aw*/w*/b* write address, data and response channels.
//        slave modport is used by the responder; master modport is used by whatever drives it.
interface axi_mem_responder_if #(
    parameter int DATA_W = 512,
    parameter int ID_W   = 16
);
    logic [ID_W-1:0]     arid_s;
    logic [63:0]         araddr_s;
    logic [7:0]          arlen_s;
    logic [2:0]          arsize_s;
    logic                arvalid_s;
    logic                arready_s;
    logic [ID_W-1:0]     rid_s;
    logic [DATA_W-1:0]   rdata_s;
    logic [1:0]          rresp_s;
    logic                rlast_s;
    logic                rvalid_s;
    logic                rready_s;
    logic [ID_W-1:0]     awid_s;
    logic [63:0]         awaddr_s;
    logic [7:0]          awlen_s;
    logic [2:0]          awsize_s;
    logic                awvalid_s;
    logic                awready_s;
    logic [ID_W-1:0]     wid_s;
    logic [DATA_W-1:0]   wdata_s;
    logic [DATA_W/8-1:0] wstrb_s;
    logic                wlast_s;
    logic                wvalid_s;
    logic                wready_s;
    logic [ID_W-1:0]     bid_s;
    logic [1:0]          bresp_s;
    logic                bvalid_s;
    logic                bready_s;

    modport slave (
        input  arid_s, araddr_s, arlen_s, arsize_s, arvalid_s, rready_s,
        input  awid_s, awaddr_s, awlen_s, awsize_s, awvalid_s,
        input  wid_s, wdata_s, wstrb_s, wlast_s, wvalid_s, bready_s,
        output arready_s, rid_s, rdata_s, rresp_s, rlast_s, rvalid_s,
        output awready_s, wready_s, bid_s, bresp_s, bvalid_s
    );

    modport master (
        output arid_s, araddr_s, arlen_s, arsize_s, arvalid_s, rready_s,
        output awid_s, awaddr_s, awlen_s, awsize_s, awvalid_s,
        output wid_s, wdata_s, wstrb_s, wlast_s, wvalid_s, bready_s,
        input  arready_s, rid_s, rdata_s, rresp_s, rlast_s, rvalid_s,
        input  awready_s, wready_s, bid_s, bresp_s, bvalid_s
    );
endinterface

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: line-addressed AXI slave memory model with read latency, strobed writes and backdoor load
// Ports: clk, reset_n (async active-low); s = AXI slave channels; ld_valid/ld_line/ld_data = backdoor
//        full-line write; rd_beats/wr_beats = R and W handshakes since reset (wrapping).
module axi_mem_responder #(
    parameter int          DATA_W     = 512,
    parameter int          ID_W       = 16,
    parameter int          LOG_LINES  = 10,
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter int          RD_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    axi_mem_responder_if.slave   s,
    input  logic                 ld_valid,
    input  logic [LOG_LINES-1:0] ld_line,
    input  logic [DATA_W-1:0]    ld_data,
    output logic [31:0]          rd_beats,
    output logic [31:0]          wr_beats
);
    localparam int NB = DATA_W / 8;

    // *_INIT holds the ready outputs low for the first edge after reset release
    typedef enum logic [1:0] {R_INIT, R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [DATA_W-1:0] r_mem [2**LOG_LINES];

    r_state_t          r_rstate, w_rnext;
    logic [ID_W-1:0]   r_rid;
    logic [57:0]       r_rline;
    logic              r_rbelow;
    logic [8:0]        r_rleft;
    logic [15:0]       r_rcnt;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;

    w_state_t          r_wstate, w_wnext;
    logic [ID_W-1:0]   r_wid;
    logic [57:0]       r_wline;
    logic              r_wbelow;
    logic [8:0]        r_wleft;
    logic              r_werr;

    logic              w_ar_fire, w_r_fire, w_aw_fire, w_w_fire;
    logic              w_rload, w_rbeat_ok, w_wok, w_wfinal, w_wen;
    logic [57:0]       w_rbeat_line;
    logic [LOG_LINES-1:0] w_widx;
    logic [DATA_W-1:0] w_wbase, w_wmerge;
    logic              w_unused;

    // A line is in range when the address is not below the base and the index fits the store
    function automatic logic in_range(input logic below, input logic [57:0] line);
        return !below && (line >> LOG_LINES) == 58'd0;
    endfunction

    assign w_unused = ^{s.arsize_s, s.awsize_s, s.wid_s};

    assign w_ar_fire    = r_rstate == R_IDLE && s.arvalid_s;
    assign w_r_fire     = r_rstate == R_DATA && s.rready_s;
    assign w_aw_fire    = r_wstate == W_IDLE && s.awvalid_s;
    assign w_w_fire     = r_wstate == W_DATA && s.wvalid_s;
    // A beat is fetched when first presented: on leaving the wait, or on a non-final R handshake
    assign w_rload      = (r_rstate == R_WAIT && r_rcnt == 16'd0) || (w_r_fire && r_rleft != 9'd1);
    assign w_rbeat_line = r_rstate == R_DATA ? r_rline + 58'd1 : r_rline;
    assign w_rbeat_ok   = in_range(r_rbelow, w_rbeat_line);
    assign w_wok        = in_range(r_wbelow, r_wline);
    assign w_wfinal     = r_wleft == 9'd1;
    assign w_wen        = w_w_fire && w_wok;
    assign w_widx       = r_wline[LOG_LINES-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rstate <= R_INIT;
            r_wstate <= W_INIT;
        end else begin
            r_rstate <= w_rnext;
            r_wstate <= w_wnext;
        end
    end

    always_comb begin
        w_rnext = r_rstate == R_INIT                   ? R_IDLE :
                  w_ar_fire                            ? R_WAIT :
                  r_rstate == R_WAIT && r_rcnt == 16'd0 ? R_DATA :
                  w_r_fire && r_rleft == 9'd1          ? R_IDLE : r_rstate;
        w_wnext = r_wstate == W_INIT                   ? W_IDLE :
                  w_aw_fire                            ? W_DATA :
                  w_w_fire && w_wfinal                 ? W_RESP :
                  r_wstate == W_RESP && s.bready_s     ? W_IDLE : r_wstate;
    end

    always_comb begin
        s.arready_s = r_rstate == R_IDLE;
        s.rvalid_s  = r_rstate == R_DATA;
        s.rlast_s   = r_rstate == R_DATA && r_rleft == 9'd1;
        s.rid_s     = r_rid;
        s.rdata_s   = r_rdata;
        s.rresp_s   = r_rstate == R_DATA ? r_rresp : 2'b00;
        s.awready_s = r_wstate == W_IDLE;
        s.wready_s  = r_wstate == W_DATA;
        s.bvalid_s  = r_wstate == W_RESP;
        s.bid_s     = r_wid;
        s.bresp_s   = r_wstate == W_RESP && r_werr ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rid    <= '0;
            r_rline  <= '0;
            r_rbelow <= 1'b0;
            r_rleft  <= '0;
            r_rcnt   <= '0;
            r_rdata  <= '0;
            r_rresp  <= 2'b00;
            rd_beats <= '0;
        end else begin
            if (w_ar_fire) begin
                r_rid    <= s.arid_s;
                r_rline  <= 58'((s.araddr_s - BASE_ADDR) >> 6);
                r_rbelow <= s.araddr_s < BASE_ADDR;
                r_rleft  <= {1'b0, s.arlen_s} + 9'd1;
                r_rcnt   <= 16'(RD_LATENCY - 1);
            end
            if (r_rstate == R_WAIT && r_rcnt != 16'd0)
                r_rcnt <= r_rcnt - 16'd1;
            if (w_rload) begin
                r_rline <= w_rbeat_line;
                r_rdata <= w_rbeat_ok ? r_mem[w_rbeat_line[LOG_LINES-1:0]] : '0;
                r_rresp <= w_rbeat_ok ? 2'b00 : 2'b10;
            end
            if (w_r_fire) begin
                r_rleft  <= r_rleft - 9'd1;
                rd_beats <= rd_beats + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wid    <= '0;
            r_wline  <= '0;
            r_wbelow <= 1'b0;
            r_wleft  <= '0;
            r_werr   <= 1'b0;
            wr_beats <= '0;
        end else begin
            if (w_aw_fire) begin
                r_wid    <= s.awid_s;
                r_wline  <= 58'((s.awaddr_s - BASE_ADDR) >> 6);
                r_wbelow <= s.awaddr_s < BASE_ADDR;
                r_wleft  <= {1'b0, s.awlen_s} + 9'd1;
                r_werr   <= 1'b0;
            end
            if (w_w_fire) begin
                if (!w_wok || s.wlast_s != w_wfinal)
                    r_werr <= 1'b1;
                r_wline  <= r_wline + 58'd1;
                r_wleft  <= r_wleft - 9'd1;
                wr_beats <= wr_beats + 32'd1;
            end
        end
    end

    // Unstrobed lanes keep the backdoor data when both hit the same line in one cycle
    always_comb begin
        w_wbase  = ld_valid && ld_line == w_widx ? ld_data : r_mem[w_widx];
        w_wmerge = w_wbase;
        for (int i = 0; i < NB; i++)
            w_wmerge[8*i +: 8] = s.wstrb_s[i] ? s.wdata_s[8*i +: 8] : w_wbase[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (ld_valid)
            r_mem[ld_line] <= ld_data;
        if (w_wen)
            r_mem[w_widx] <= w_wmerge;
    end
endmodule
